// File: rtl/uart_tx_if.sv
// uart_tx_if -- handshake and line signals of the UART transmitter.
//   iData_tx : byte offered for transmission (low BIT_LENGTH bits are sent)
//   iValid   : producer offers iData_tx
//   oReady   : holding register is empty and can take a byte
//   iCTS     : clear-to-send, gates the start of a new frame
//   oTx      : serial line, idles high
//   oBusy    : a frame is on the line
//   oDone    : one-cycle pulse after the final stop bit
// master = producer side (testbench / host), slave = the transmitter.
interface uart_tx_if;
  logic [7:0] iData_tx;
  logic       iValid;
  logic       oReady;
  logic       iCTS;
  logic       oTx;
  logic       oBusy;
  logic       oDone;

  modport master (
    output iData_tx, iValid, iCTS,
    input  oReady, oTx, oBusy, oDone
  );

  modport slave (
    input  iData_tx, iValid, iCTS,
    output oReady, oTx, oBusy, oDone
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter with a 1-deep holding register and CTS gating.
//   iClk : rising-edge clock
//   iRst : synchronous active-high reset
//   bus  : uart_tx_if.slave (iData_tx, iValid, oReady, iCTS, oTx, oBusy, oDone)
// Frame: start(0), BIT_LENGTH data bits LSB first, optional parity,
// STOP_BITS stop bits(1). Every bit lasts DIV = CLK_FREQ/BAUD_RATE cycles.
//
// state  | meaning
// IDLE   | line high, waiting for a full holding register and iCTS=1
// START  | start bit (0) on the line
// DATA   | data bits, LSB first, bit_idx counts the bit being sent
// PARITY | parity bit (only when PARITY_TYPE != 0)
// STOP   | stop bit(s), bit_idx counts the stop bit being sent
module uart_tx #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int BIT_LENGTH  = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic     iClk,
  input  logic     iRst,
  uart_tx_if.slave bus
);

  localparam int              DIV       = CLK_FREQ / BAUD_RATE;
  localparam int              CNT_W     = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);
  localparam logic [2:0]      LAST_DATA = 3'(BIT_LENGTH - 1);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0]      DATA_MASK = 8'((1 << BIT_LENGTH) - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             done_q, done_d;

  logic accept;
  logic start_ok;
  logic launch;
  logic baud_tc;
  logic par_even;
  logic tx_s;
  logic busy_s;

  assign accept   = bus.iValid & ~hold_full_q;
  // iCTS only matters at the moment a frame could begin.
  assign start_ok = hold_full_q & bus.iCTS;
  assign baud_tc  = (baud_q == '0);
  assign par_even = ^(hold_q & DATA_MASK);

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    done_d      = 1'b0;
    launch      = 1'b0;

    // Accept and launch never coincide: accept needs an empty register,
    // launch needs a full one.
    if (accept) begin
      hold_d      = bus.iData_tx;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) launch = 1'b1;
      end
      START: begin
        if (baud_tc) begin
          state_d   = DATA;
          baud_d    = CNT_LOAD;
          bit_idx_d = '0;
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = CNT_LOAD;
          if (bit_idx_q == LAST_DATA) begin
            state_d   = (PARITY_TYPE != 0) ? PARITY : STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      PARITY: begin
        if (baud_tc) begin
          state_d   = STOP;
          baud_d    = CNT_LOAD;
          bit_idx_d = '0;
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_tc) begin
          if (bit_idx_q == LAST_STOP) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            // Chain straight into the next frame when a byte is waiting.
            if (start_ok) begin
              launch = 1'b1;
            end else begin
              state_d = IDLE;
              baud_d  = '0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            baud_d    = CNT_LOAD;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        baud_d    = '0;
        bit_idx_d = '0;
      end
    endcase

    // Move the pending byte into the shifter and free the holding register.
    if (launch) begin
      state_d     = START;
      shift_d     = hold_q;
      parity_d    = (PARITY_TYPE == 1) ? ~par_even : par_even;
      hold_full_d = 1'b0;
      baud_d      = CNT_LOAD;
      bit_idx_d   = '0;
    end
  end

  // Outputs.
  always_comb begin
    tx_s   = 1'b1;
    busy_s = 1'b1;
    case (state_q)
      IDLE:    busy_s = 1'b0;
      START:   tx_s   = 1'b0;
      DATA:    tx_s   = shift_q[0];
      PARITY:  tx_s   = parity_q;
      STOP:    tx_s   = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  assign bus.oTx    = tx_s;
  assign bus.oBusy  = busy_s;
  assign bus.oReady = ~hold_full_q;
  assign bus.oDone  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- four transmitter instances (8N1, 8E1, 8O1, 7N2) at DIV=16,
// checked against a frame model built from the data byte and frame settings.
module tb_uart_tx;

  localparam int DIV = 16;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  uart_tx_if b0 ();
  uart_tx_if b1 ();
  uart_tx_if b2 ();
  uart_tx_if b3 ();

  uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .BIT_LENGTH(8), .PARITY_TYPE(0), .STOP_BITS(1))
    u0 (.iClk(iClk), .iRst(iRst), .bus(b0.slave));
  uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .BIT_LENGTH(8), .PARITY_TYPE(2), .STOP_BITS(1))
    u1 (.iClk(iClk), .iRst(iRst), .bus(b1.slave));
  uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .BIT_LENGTH(8), .PARITY_TYPE(1), .STOP_BITS(1))
    u2 (.iClk(iClk), .iRst(iRst), .bus(b2.slave));
  uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .BIT_LENGTH(7), .PARITY_TYPE(0), .STOP_BITS(2))
    u3 (.iClk(iClk), .iRst(iRst), .bus(b3.slave));

  // Frame settings of each instance, used by the model.
  int nbits_t [4] = '{8, 8, 8, 7};
  int par_t   [4] = '{0, 2, 1, 0};
  int stop_t  [4] = '{1, 1, 1, 2};

  logic [7:0] data_v [4];
  logic [3:0] valid_v, cts_v;
  logic [3:0] tx_v, busy_v, ready_v, done_v;

  assign b0.iData_tx = data_v[0]; assign b0.iValid = valid_v[0]; assign b0.iCTS = cts_v[0];
  assign b1.iData_tx = data_v[1]; assign b1.iValid = valid_v[1]; assign b1.iCTS = cts_v[1];
  assign b2.iData_tx = data_v[2]; assign b2.iValid = valid_v[2]; assign b2.iCTS = cts_v[2];
  assign b3.iData_tx = data_v[3]; assign b3.iValid = valid_v[3]; assign b3.iCTS = cts_v[3];

  assign tx_v    = {b3.oTx,    b2.oTx,    b1.oTx,    b0.oTx};
  assign busy_v  = {b3.oBusy,  b2.oBusy,  b1.oBusy,  b0.oBusy};
  assign ready_v = {b3.oReady, b2.oReady, b1.oReady, b0.oReady};
  assign done_v  = {b3.oDone,  b2.oDone,  b1.oDone,  b0.oDone};

  int   checks = 0;
  int   errors = 0;
  logic exp_bits [16];
  int   exp_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line image of one frame, one entry per bit period.
  task automatic build_frame(input int k, input logic [7:0] d);
    int ones;
    ones = 0;
    exp_len = 0;
    exp_bits[exp_len] = 1'b0;
    exp_len++;
    for (int i = 0; i < nbits_t[k]; i++) begin
      exp_bits[exp_len] = d[i];
      ones += int'(d[i]);
      exp_len++;
    end
    if (par_t[k] != 0) begin
      // Even: total ones incl. parity is even; odd: total is odd.
      exp_bits[exp_len] = (par_t[k] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      exp_len++;
    end
    for (int i = 0; i < stop_t[k]; i++) begin
      exp_bits[exp_len] = 1'b1;
      exp_len++;
    end
  endtask

  task automatic offer(input int k, input logic [7:0] d);
    int n;
    n = 0;
    while (ready_v[k] !== 1'b1 && n < 400) begin
      @(negedge iClk);
      n++;
    end
    chk($sformatf("offer_ready_u%0d", k), 32'(ready_v[k]), 32'd1);
    data_v[k]  = d;
    valid_v[k] = 1'b1;
    @(negedge iClk);
    valid_v[k] = 1'b0;
    chk($sformatf("ready_drop_u%0d", k), 32'(ready_v[k]), 32'd0);
  endtask

  task automatic wait_start(input int k);
    int n;
    n = 0;
    while (tx_v[k] !== 1'b0 && n < 400) begin
      @(negedge iClk);
      n++;
    end
    chk($sformatf("start_seen_u%0d", k), 32'(tx_v[k]), 32'd0);
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the
  // negedge where oDone must be high.
  task automatic check_frame(input int k, input bit offer_next, input logic [7:0] next_d,
                             input bit drop_cts);
    for (int b = 0; b < exp_len; b++) begin
      int   bad_ctl;
      int   cyc;
      logic last_obs;
      bad_ctl  = 0;
      last_obs = exp_bits[b];
      for (int c = 0; c < DIV; c++) begin
        cyc = b * DIV + c;
        if (cyc > 0) @(negedge iClk);
        if (tx_v[k] !== exp_bits[b]) last_obs = tx_v[k];
        if (busy_v[k] !== 1'b1) bad_ctl++;
        if (cyc > 0 && done_v[k] !== 1'b0) bad_ctl++;
        if (offer_next && cyc == 1) begin
          data_v[k]  = next_d;
          valid_v[k] = 1'b1;
        end
        if (offer_next && cyc == 2) begin
          valid_v[k] = 1'b0;
          chk($sformatf("ready_midframe_u%0d", k), 32'(ready_v[k]), 32'd0);
        end
        if (drop_cts && cyc == 40) cts_v[k] = 1'b0;
      end
      chk($sformatf("tx_u%0d_bit%0d", k, b), 32'(last_obs), 32'(exp_bits[b]));
      chk($sformatf("busy_done_u%0d_bit%0d", k, b), 32'(bad_ctl), 32'd0);
    end
    @(negedge iClk);
    chk($sformatf("done_pulse_u%0d", k), 32'(done_v[k]), 32'd1);
  endtask

  task automatic idle_after(input int k);
    @(negedge iClk);
    chk($sformatf("done_single_u%0d", k), 32'(done_v[k]), 32'd0);
    chk($sformatf("busy_idle_u%0d", k), 32'(busy_v[k]), 32'd0);
    chk($sformatf("tx_idle_u%0d", k), 32'(tx_v[k]), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    int         bad;
    int         n;
    logic [7:0] d;

    iRst    = 1'b1;
    valid_v = '0;
    cts_v   = '1;
    for (int i = 0; i < 4; i++) data_v[i] = '0;
    repeat (3) @(negedge iClk);
    chk("rst_tx",    32'(tx_v),    32'hF);
    chk("rst_ready", 32'(ready_v), 32'hF);
    chk("rst_busy",  32'(busy_v),  32'h0);
    chk("rst_done",  32'(done_v),  32'h0);
    iRst = 1'b0;
    @(negedge iClk);

    // 0xA5 on 8N1 against the literal line pattern 0,1,0,1,0,0,1,0,1,1.
    offer(0, 8'hA5);
    wait_start(0);
    pat = 10'b1101001010;
    exp_len = 10;
    for (int i = 0; i < 10; i++) exp_bits[i] = pat[i];
    check_frame(0, 1'b0, 8'h00, 1'b0);
    idle_after(0);

    // Parity: 0xA5 even, 0xA5 odd, 0x01 even.
    offer(1, 8'hA5); wait_start(1); build_frame(1, 8'hA5);
    check_frame(1, 1'b0, 8'h00, 1'b0); idle_after(1);
    offer(2, 8'hA5); wait_start(2); build_frame(2, 8'hA5);
    check_frame(2, 1'b0, 8'h00, 1'b0); idle_after(2);
    offer(1, 8'h01); wait_start(1); build_frame(1, 8'h01);
    check_frame(1, 1'b0, 8'h00, 1'b0); idle_after(1);

    // 7 data bits, 2 stop bits; bit 7 of the input must not appear.
    offer(3, 8'h7F); wait_start(3); build_frame(3, 8'h7F);
    check_frame(3, 1'b0, 8'h00, 1'b0); idle_after(3);
    offer(3, 8'hFF); wait_start(3); build_frame(3, 8'hFF);
    check_frame(3, 1'b0, 8'h00, 1'b0); idle_after(3);

    // Back to back: 0xC3 offered during 0x3C, second start follows the
    // final stop bit with no gap.
    offer(0, 8'h3C); wait_start(0); build_frame(0, 8'h3C);
    check_frame(0, 1'b1, 8'hC3, 1'b0);
    build_frame(0, 8'hC3);
    check_frame(0, 1'b0, 8'h00, 1'b0);
    idle_after(0);

    // CTS held low with a byte pending, then raised; dropped again mid-frame.
    cts_v[0] = 1'b0;
    offer(0, 8'h5A);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    chk("cts_hold_line", 32'(bad), 32'd0);
    cts_v[0] = 1'b1;
    n = 0;
    while (tx_v[0] !== 1'b0 && n < 2) begin
      @(negedge iClk);
      n++;
    end
    chk("cts_start_2cyc", 32'(tx_v[0]), 32'd0);
    build_frame(0, 8'h5A);
    check_frame(0, 1'b0, 8'h00, 1'b1);
    idle_after(0);
    cts_v[0] = 1'b1;

    // Reset in the middle of DATA with a second byte pending.
    offer(0, 8'h96);
    wait_start(0);
    repeat (30) @(negedge iClk);
    data_v[0]  = 8'h11;
    valid_v[0] = 1'b1;
    @(negedge iClk);
    valid_v[0] = 1'b0;
    chk("rst_mid_ready_before", 32'(ready_v[0]), 32'd0);
    iRst = 1'b1;
    @(negedge iClk);
    chk("rst_mid_tx",    32'(tx_v[0]),    32'd1);
    chk("rst_mid_busy",  32'(busy_v[0]),  32'd0);
    chk("rst_mid_ready", 32'(ready_v[0]), 32'd1);
    chk("rst_mid_done",  32'(done_v[0]),  32'd0);
    iRst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iClk);
      if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
    end
    chk("rst_mid_discard", 32'(bad), 32'd0);

    // Random bytes on every configuration.
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 6; r++) begin
        d = 8'($urandom_range(0, 255));
        offer(k, d);
        wait_start(k);
        build_frame(k, d);
        check_frame(k, 1'b0, 8'h00, 1'b0);
        idle_after(k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
